// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the multi-channel key debouncer.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    // Bits needed to hold 0..limit; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key pins in, debounced levels and event pulses out.
interface key_debounce_if #(
    parameter int unsigned N_KEYS = 4
);
    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] release_pulse;
    logic [N_KEYS-1:0] long_pulse;
    logic [N_KEYS-1:0] repeat_pulse;

    modport master (
        output key_in,
        input  key_state, press_pulse, release_pulse, long_pulse, repeat_pulse
    );

    modport slave (
        input  key_in,
        output key_state, press_pulse, release_pulse, long_pulse, repeat_pulse
    );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchronizer, debounce counter, press/long/repeat FSM.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_pin,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);
    localparam logic        RELEASED_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam int unsigned DW           = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_MAX     = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HW           = cnt_width(HOLD_MAX);
    localparam logic [DW-1:0] DB_TERM    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_TERM  = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] REP_TERM   = HW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    state_t        state_q, state_d;
    logic          key_state_d, press_d, release_d, long_d, repeat_d;
    logic          press_acc, rel_acc;

    assign level = sync_q[1] ^ RELEASED_PIN;

    // Debounce acceptance and event FSM; release takes priority over hold events.
    always_comb begin
        db_cnt_d    = db_cnt_q;
        key_state_d = key_state;
        hold_d      = hold_q;
        state_d     = state_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;
        press_acc   = 1'b0;
        rel_acc     = 1'b0;

        if (level == key_state) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_TERM) begin
            db_cnt_d    = '0;
            key_state_d = level;
            press_acc   = level;
            rel_acc     = ~level;
        end else begin
            db_cnt_d = db_cnt_q + DW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (press_acc) begin
                    state_d = ST_PRESSED;
                    hold_d  = '0;
                    press_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (rel_acc) begin
                    state_d   = ST_IDLE;
                    hold_d    = '0;
                    release_d = 1'b1;
                end else if (hold_q == LONG_TERM) begin
                    state_d = ST_HELD;
                    hold_d  = '0;
                    long_d  = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_HELD: begin
                if (rel_acc) begin
                    state_d   = ST_IDLE;
                    hold_d    = '0;
                    release_d = 1'b1;
                end else if (REPEAT_CYCLES == 0) begin
                    hold_d = '0;
                end else if (hold_q == REP_TERM) begin
                    hold_d   = '0;
                    repeat_d = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q        <= {2{RELEASED_PIN}};
            db_cnt_q      <= '0;
            hold_q        <= '0;
            state_q       <= ST_IDLE;
            key_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], key_pin};
            db_cnt_q      <= db_cnt_d;
            hold_q        <= hold_d;
            state_q       <= state_d;
            key_state     <= key_state_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= long_d;
            repeat_pulse  <= repeat_d;
        end
    end

endmodule

// File: rtl/key_debounce_array.sv
// N independent debounced key channels with press/release/long/repeat events.
module key_debounce_array
    import key_debounce_pkg::*;
#(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
    input  logic           clk,
    input  logic           rst,
    key_debounce_if.slave  bus
);
    if (N_KEYS < 1) begin : g_bad_n_keys
        $error("key_debounce_array: N_KEYS must be >= 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_debounce_array: DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("key_debounce_array: LONG_CYCLES must be >= 1");
    end

    logic [N_KEYS-1:0] st, prs, rel, lng, rpt;

    for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_ch
        key_debounce_ch #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .key_pin       (bus.key_in[i]),
            .key_state     (st[i]),
            .press_pulse   (prs[i]),
            .release_pulse (rel[i]),
            .long_pulse    (lng[i]),
            .repeat_pulse  (rpt[i])
        );
    end

    assign bus.key_state     = st;
    assign bus.press_pulse   = prs;
    assign bus.release_pulse = rel;
    assign bus.long_pulse    = lng;
    assign bus.repeat_pulse  = rpt;

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench for key_debounce_array: main config plus no-repeat and active-high variants.
module tb_key_debounce_array;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cp[4], cr[4], cl[4], ct[4];
    int   r0_rep, r0_long;

    always #5 clk = ~clk;

    key_debounce_if #(.N_KEYS(4)) bus_m  ();
    key_debounce_if #(.N_KEYS(4)) bus_r0 ();
    key_debounce_if #(.N_KEYS(4)) bus_al ();

    key_debounce_array #(.N_KEYS(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(8),
                         .LONG_CYCLES(32), .REPEAT_CYCLES(10))
        dut_m (.clk(clk), .rst(rst), .bus(bus_m));
    key_debounce_array #(.N_KEYS(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(8),
                         .LONG_CYCLES(32), .REPEAT_CYCLES(0))
        dut_r0 (.clk(clk), .rst(rst), .bus(bus_r0));
    key_debounce_array #(.N_KEYS(4), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(8),
                         .LONG_CYCLES(32), .REPEAT_CYCLES(10))
        dut_al (.clk(clk), .rst(rst), .bus(bus_al));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int c = 0; c < 4; c++) begin
            cp[c] = 0; cr[c] = 0; cl[c] = 0; ct[c] = 0;
        end
        r0_rep  = 0;
        r0_long = 0;
    endtask

    // Advance n clock cycles, sampling and tallying pulses on each falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                cp[c] += int'(bus_m.press_pulse[c]);
                cr[c] += int'(bus_m.release_pulse[c]);
                cl[c] += int'(bus_m.long_pulse[c]);
                ct[c] += int'(bus_m.repeat_pulse[c]);
            end
            r0_rep  += $countones(bus_r0.repeat_pulse);
            r0_long += $countones(bus_r0.long_pulse);
        end
    endtask

    function automatic logic [31:0] all_out_m();
        return {12'd0, bus_m.key_state, bus_m.press_pulse, bus_m.release_pulse,
                bus_m.long_pulse, bus_m.repeat_pulse};
    endfunction

    initial begin
        bus_m.key_in  = 4'hF;
        bus_r0.key_in = 4'hF;
        bus_al.key_in = 4'h0;
        clr();

        // Reset state
        tick(3);
        chk("reset_outputs_m", all_out_m(), 32'd0);
        rst = 1'b0;
        tick(4);
        chk("idle_outputs_m", all_out_m(), 32'd0);
        chk("idle_state_al", {28'd0, bus_al.key_state}, 32'd0);
        chk("idle_state_r0", {28'd0, bus_r0.key_state}, 32'd0);

        // Clean press and release on key 0
        clr();
        bus_m.key_in[0] = 1'b0;
        tick(9);
        chk("clean_press_early", {28'd0, bus_m.press_pulse}, 32'd0);
        chk("clean_state_early", {28'd0, bus_m.key_state}, 32'd0);
        tick(1);
        chk("clean_press", {28'd0, bus_m.press_pulse}, 32'h1);
        chk("clean_state_on", {28'd0, bus_m.key_state}, 32'h1);
        tick(1);
        chk("clean_press_width", {28'd0, bus_m.press_pulse}, 32'd0);
        tick(9);
        bus_m.key_in[0] = 1'b1;
        tick(9);
        chk("clean_release_early", {28'd0, bus_m.release_pulse}, 32'd0);
        chk("clean_state_held", {28'd0, bus_m.key_state}, 32'h1);
        tick(1);
        chk("clean_release", {28'd0, bus_m.release_pulse}, 32'h1);
        chk("clean_state_off", {28'd0, bus_m.key_state}, 32'd0);
        tick(3);
        chk("clean_press_count", 32'(cp[0]), 32'd1);
        chk("clean_release_count", 32'(cr[0]), 32'd1);

        // Bounce rejection on key 1: five 7-cycle low glitches
        clr();
        for (int g = 0; g < 5; g++) begin
            bus_m.key_in[1] = 1'b0;
            tick(7);
            bus_m.key_in[1] = 1'b1;
            tick(3);
        end
        chk("bounce_press_count", 32'(cp[1]), 32'd0);
        chk("bounce_release_count", 32'(cr[1]), 32'd0);
        chk("bounce_state", {28'd0, bus_m.key_state}, 32'd0);
        bus_m.key_in[1] = 1'b0;
        tick(9);
        chk("bounce_press_early", {28'd0, bus_m.press_pulse}, 32'd0);
        tick(1);
        chk("bounce_press", {28'd0, bus_m.press_pulse}, 32'h2);
        bus_m.key_in[1] = 1'b1;
        tick(12);
        chk("bounce_released", {28'd0, bus_m.key_state}, 32'd0);

        // Long press with repeat on key 2, held 80 cycles
        clr();
        bus_m.key_in[2] = 1'b0;
        tick(10);
        chk("long_press", {28'd0, bus_m.press_pulse}, 32'h4);
        tick(31);
        chk("long_early_count", 32'(cl[2]), 32'd0);
        tick(1);
        chk("long_pulse_at_32", {28'd0, bus_m.long_pulse}, 32'h4);
        tick(9);
        chk("repeat_early_count", 32'(ct[2]), 32'd0);
        tick(1);
        chk("repeat_at_42", {28'd0, bus_m.repeat_pulse}, 32'h4);
        tick(10);
        chk("repeat_at_52", {28'd0, bus_m.repeat_pulse}, 32'h4);
        tick(18);
        bus_m.key_in[2] = 1'b1;
        tick(10);
        chk("long_release", {28'd0, bus_m.release_pulse}, 32'h4);
        chk("long_release_no_rpt", {28'd0, bus_m.repeat_pulse}, 32'd0);
        tick(20);
        chk("repeat_total", 32'(ct[2]), 32'd4);
        chk("long_total", 32'(cl[2]), 32'd1);

        // Release acceptance collides with the long terminal count on key 3
        clr();
        bus_m.key_in[3] = 1'b0;
        tick(10);
        chk("coll_press", {28'd0, bus_m.press_pulse}, 32'h8);
        tick(22);
        bus_m.key_in[3] = 1'b1;
        tick(10);
        chk("coll_release", {28'd0, bus_m.release_pulse}, 32'h8);
        chk("coll_no_long", {28'd0, bus_m.long_pulse}, 32'd0);
        tick(20);
        chk("coll_long_count", 32'(cl[3]), 32'd0);
        chk("coll_repeat_count", 32'(ct[3]), 32'd0);

        // Reset asserted while key 0 is in HELD
        clr();
        bus_m.key_in[0] = 1'b0;
        tick(10);
        chk("rst_press_first", {28'd0, bus_m.press_pulse}, 32'h1);
        tick(32);
        chk("rst_long_first", {28'd0, bus_m.long_pulse}, 32'h1);
        tick(3);
        rst = 1'b1;
        #1;
        chk("rst_immediate", all_out_m(), 32'd0);
        tick(3);
        chk("rst_held", all_out_m(), 32'd0);
        rst = 1'b0;
        tick(9);
        chk("rst_press_early", {28'd0, bus_m.press_pulse}, 32'd0);
        tick(1);
        chk("rst_press_again", {28'd0, bus_m.press_pulse}, 32'h1);
        bus_m.key_in[0] = 1'b1;
        tick(12);
        chk("rst_released", {28'd0, bus_m.key_state}, 32'd0);

        // All four keys pressed on the same edge
        clr();
        bus_m.key_in = 4'h0;
        tick(10);
        chk("all_press", {28'd0, bus_m.press_pulse}, 32'hF);
        chk("all_state", {28'd0, bus_m.key_state}, 32'hF);
        bus_m.key_in = 4'hF;
        tick(10);
        chk("all_release", {28'd0, bus_m.release_pulse}, 32'hF);

        // REPEAT_CYCLES = 0: long pulse but never a repeat
        clr();
        bus_r0.key_in[0] = 1'b0;
        tick(10);
        chk("r0_press", {28'd0, bus_r0.press_pulse}, 32'h1);
        tick(32);
        chk("r0_long", {28'd0, bus_r0.long_pulse}, 32'h1);
        tick(40);
        chk("r0_no_repeat", 32'(r0_rep), 32'd0);
        chk("r0_long_count", 32'(r0_long), 32'd1);
        bus_r0.key_in[0] = 1'b1;
        tick(10);
        chk("r0_release", {28'd0, bus_r0.release_pulse}, 32'h1);

        // ACTIVE_LOW = 0: pin high means pressed
        bus_al.key_in[1] = 1'b1;
        tick(9);
        chk("al_press_early", {28'd0, bus_al.press_pulse}, 32'd0);
        tick(1);
        chk("al_press", {28'd0, bus_al.press_pulse}, 32'h2);
        chk("al_state", {28'd0, bus_al.key_state}, 32'h2);
        bus_al.key_in[1] = 1'b0;
        tick(10);
        chk("al_release", {28'd0, bus_al.release_pulse}, 32'h2);
        chk("al_state_off", {28'd0, bus_al.key_state}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debounce_array.md
# key_debounce_array

Parametrised multi-channel key debouncer and event generator. It replaces single-key, single-pulse debouncing for front-panel buttons that drive display test-pattern and mode selection. It handles N independent keys, each with a 2-FF synchronizer, and emits per-key press, release, long-press and auto-repeat pulses. It sits between the board key pins and the control/UART-config logic, in the system clock domain.

## Interface
- `N_KEYS`, default 4: number of independent key channels (≥1).
- `ACTIVE_LOW`, default 1: 1 means the pin level 0 is "pressed"; 0 means the pin level 1 is "pressed".
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive stable cycles needed to accept a level change (20 ms at 50 MHz). Must be ≥1.
- `LONG_CYCLES`, default 50_000_000: hold time after press acceptance before `long_pulse` (1 s). Must be ≥1.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period after long press (200 ms). The value 0 disables repeat.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `key_in` in N_KEYS: raw asynchronous key pins.
- `key_state` out N_KEYS: debounced level, 1 = pressed.
- `press_pulse` out N_KEYS: one-cycle pulse on accepted press.
- `release_pulse` out N_KEYS: one-cycle pulse on accepted release.
- `long_pulse` out N_KEYS: one-cycle pulse when a key has been held LONG_CYCLES.
- `repeat_pulse` out N_KEYS: one-cycle pulse every REPEAT_CYCLES after `long_pulse` while the key stays held.

## Operation
- **Channel independence.** Channels are fully independent. Simultaneous activity on several channels produces independent, possibly coincident, pulses.
- **Synchronization and normalization.** Each pin is synchronized by 2 FFs. The synchronizer resets to the released level. The synced level is then normalized to pressed=1 using ACTIVE_LOW.
- **Debounce counter.**
  - The counter is cleared whenever the synced level equals `key_state`.
  - Otherwise it increments.
  - On the cycle it would reach DEBOUNCE_CYCLES, `key_state` flips, the counter clears, and the matching `press_pulse` or `release_pulse` fires.
  - A glitch shorter than DEBOUNCE_CYCLES produces no event and no state change.
- **Per-channel FSM.**
  - IDLE → PRESSED on an accepted press. The hold counter clears.
  - PRESSED → HELD when the hold counter reaches LONG_CYCLES. Fire `long_pulse`; the hold counter clears.
  - HELD: if REPEAT_CYCLES>0, fire `repeat_pulse` each time the hold counter reaches REPEAT_CYCLES, then clear it. If REPEAT_CYCLES=0, the counter stays at 0.
  - PRESSED or HELD → IDLE on an accepted release. Fire `release_pulse`; the hold counter clears.
- **Release priority.** Release wins. No `long_pulse` or `repeat_pulse` fires in the same cycle as `release_pulse` or after it.
- **Counter widths.** Counters are sized `$clog2(max+1)` of their limit. Counters never wrap: each clears at its terminal count.

## Timing
- **Reset values.** All outputs are 0 during and after reset. FSM is IDLE; counters and synchronizers are at the released level.
- **Press and release latency.** If the pin level changes and is first sampled at edge k, then `key_state` and `press_pulse` (or `release_pulse`) are high in the cycle following edge k+DEBOUNCE_CYCLES+1. That is a fixed latency of DEBOUNCE_CYCLES+2 cycles.
- **Long-press timing.** `long_pulse` fires exactly LONG_CYCLES cycles after `press_pulse`.
- **Repeat timing.** The first `repeat_pulse` fires REPEAT_CYCLES cycles after `long_pulse`, then every REPEAT_CYCLES cycles.
- **Pulse width.** Every pulse is exactly 1 cycle wide. Outputs are registered, with no combinational path from `key_in`.
- **Reset mid-press.** All events are aborted immediately. If the key is still held when `rst` is released, a fresh `press_pulse` follows DEBOUNCE_CYCLES+2 cycles later.

## Structure
- Package `key_debounce_pkg` holds:
  - the FSM state enum (IDLE, PRESSED, HELD);
  - a `cnt_width(limit)` function for counter sizing.
- Sub-module `key_debounce_ch` implements one channel: synchronizer, debounce counter, FSM, hold counter, and the 5 outputs.
- The top instantiates N_KEYS copies in a generate loop and checks parameter legality at elaboration.

## Test plan
All scenarios use N_KEYS=4, ACTIVE_LOW=1, DEBOUNCE_CYCLES=8, LONG_CYCLES=32, REPEAT_CYCLES=10.
- **Clean press and release.** `key_in[0]` is driven 0 for 20 cycles, then 1. Required: `press_pulse[0]` 10 cycles after the falling edge, `release_pulse[0]` 10 cycles after the rising edge, and `key_state[0]` high between them.
- **Bounce rejection.** `key_in[1]` toggles with 7-cycle low periods ×5. Required: no pulses and `key_state[1]`=0. Then hold low: `press_pulse[1]` exactly 10 cycles after the final edge.
- **Long press with repeat.** Hold `key_in[2]` low for 80 cycles. Required pulse positions, relative to `press_pulse`:
  - `long_pulse` at +32;
  - `repeat_pulse` at +42 and +52;
  - then releases; no repeat after `release_pulse`.
- **Release vs. long collision.** Time the release so its acceptance lands in the same cycle as the long terminal count. Required: only `release_pulse`, and no `long_pulse`.
- **Reset mid-hold.** Assert `rst` in HELD state for 3 cycles while the key is still low. Required: all outputs 0 immediately, then `press_pulse` 10 cycles after `rst` deasserts.
- **Independence and config variants.** Press all 4 keys on the same edge: 4 coincident `press_pulse` bits. Rerun with REPEAT_CYCLES=0 (no repeats ever) and with ACTIVE_LOW=0 (inverted polarity works).
